// File: rtl/demux_pkg.sv
// demux_pkg: shared packet-FSM state type and select-width helper for the stream demux.
package demux_pkg;
  typedef enum logic {IDLE, LOCKED} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/demux1_n_decode.sv
// demux1_n_decode: SEL_W -> N one-hot decoder with an out-of-range flag.
//   sel    : channel index
//   onehot : bit sel set when sel < N, else all zero
//   oor    : sel >= N
module demux1_n_decode
  import demux_pkg::*;
#(
  parameter int N     = 8,
  parameter int SEL_W = clog2(N)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     onehot,
  output logic             oor
);
  logic [(1<<SEL_W)-1:0] full;
  always_comb begin
    full        = '0;
    full[sel]   = 1'b1;
    onehot      = full[N-1:0];
    oor         = ~|onehot;
  end
endmodule

// File: rtl/demux1_n_stream.sv
// demux1_n_stream: registered 1-to-N valid/ready stream demux with optional packet lock.
//   a/a_valid/a_last/s/a_ready : producer side, beat routed to channel s
//   y/y_valid/y_ready          : N consumer channels, slot k = y[k*DATA_W +: DATA_W]
//   err                        : one-cycle pulse per beat dropped for an out-of-range select
module demux1_n_stream
  import demux_pkg::*;
#(
  parameter int N        = 8,
  parameter int DATA_W   = 8,
  parameter int PKT_MODE = 0,
  localparam int SEL_W   = clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   a,
  input  logic                a_valid,
  input  logic                a_last,
  input  logic [SEL_W-1:0]    s,
  output logic                a_ready,
  output logic [N*DATA_W-1:0] y,
  output logic [N-1:0]        y_valid,
  input  logic [N-1:0]        y_ready,
  output logic                err
);
  state_t            state_q, state_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d, buf_ch_q, buf_ch_d, eff_ch;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              buf_full_q, buf_full_d, err_q, err_d;
  logic              accept, load, drain, eff_oor, buf_oor;
  logic [N-1:0]      buf_hot, eff_hot;
  demux1_n_decode #(.N(N), .SEL_W(SEL_W)) u_buf_dec (.sel(buf_ch_q), .onehot(buf_hot), .oor(buf_oor));
  demux1_n_decode #(.N(N), .SEL_W(SEL_W)) u_eff_dec (.sel(eff_ch), .onehot(eff_hot), .oor(eff_oor));
  // Once a packet is locked, the stored channel overrides s for every remaining beat.
  assign eff_ch  = (PKT_MODE != 0 && state_q == LOCKED) ? lock_ch_q : s;
  assign y_valid = (buf_full_q & ~buf_oor) ? buf_hot : '0;
  // Only the buffered channel's ready matters; y_valid has at most that bit set.
  assign drain   = |(y_valid & y_ready);
  assign a_ready = ~rst & (~buf_full_q | drain);
  assign err     = err_q;
  for (genvar k = 0; k < N; k++) begin : g_slot
    assign y[k*DATA_W +: DATA_W] = y_valid[k] ? buf_data_q : '0;
  end
  always_comb begin
    accept     = a_valid & a_ready;
    load       = accept & |eff_hot;
    buf_full_d = load | (buf_full_q & ~drain);
    buf_data_d = load ? a : buf_data_q;
    buf_ch_d   = load ? eff_ch : buf_ch_q;
    err_d      = accept & eff_oor;
    state_d    = (PKT_MODE == 0 || !accept) ? state_q : a_last ? IDLE : LOCKED;
    lock_ch_d  = (PKT_MODE != 0 && accept && state_q == IDLE && !a_last) ? s : lock_ch_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_ch_q  <= '0;
      buf_ch_q   <= '0;
      buf_data_q <= '0;
      buf_full_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_ch_q  <= lock_ch_d;
      buf_ch_q   <= buf_ch_d;
      buf_data_q <= buf_data_d;
      buf_full_q <= buf_full_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_demux1_n_stream.sv
// tb_demux1_n_stream: scoreboard bench for per-beat (N=8, N=6) and packet-mode (N=6) demux variants.
module tb_demux1_n_stream;
  typedef struct {int ch; logic [7:0] d; bit e;} exp_t;
  logic clk = 0, rst = 1;
  logic [7:0] a = '0;
  logic [2:0] s = '0;
  logic a_last = 0, av0 = 0, av1 = 0, av2 = 0;
  logic ar0, ar1, ar2, err0, err1, err2;
  logic [63:0] y0;
  logic [47:0] y1, y2;
  logic [7:0] yv0, yr0 = '1;
  logic [5:0] yv1, yv2, yr1 = '1, yr2 = '1;
  int errors = 0, checks = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  demux1_n_stream #(.N(8), .DATA_W(8), .PKT_MODE(0)) d0 (.clk(clk), .rst(rst), .a(a), .a_valid(av0), .a_last(a_last), .s(s),
    .a_ready(ar0), .y(y0), .y_valid(yv0), .y_ready(yr0), .err(err0));
  demux1_n_stream #(.N(6), .DATA_W(8), .PKT_MODE(0)) d1 (.clk(clk), .rst(rst), .a(a), .a_valid(av1), .a_last(a_last), .s(s),
    .a_ready(ar1), .y(y1), .y_valid(yv1), .y_ready(yr1), .err(err1));
  demux1_n_stream #(.N(6), .DATA_W(8), .PKT_MODE(1)) d2 (.clk(clk), .rst(rst), .a(a), .a_valid(av2), .a_last(a_last), .s(s),
    .a_ready(ar2), .y(y2), .y_valid(yv2), .y_ready(yr2), .err(err2));

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (ar0 !== 1'b0) begin errors++; $display("FAIL rst_a_ready got=%b want=0", ar0); end
    checks++; if (yv0 !== 8'h00) begin errors++; $display("FAIL rst_y_valid got=%h want=00", yv0); end
    checks++; if (y0 !== 64'h0) begin errors++; $display("FAIL rst_y got=%h want=0", y0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rst_err got=%b want=0", err0); end
    rst = 0;
    #1;
    checks++; if ({ar0, ar1, ar2} !== 3'b111) begin errors++; $display("FAIL release_a_ready got=%b want=111", {ar0, ar1, ar2}); end
    @(negedge clk);
    yr0 = 8'hF7; s = 3; a = 8'hC3; av0 = 1;
    @(negedge clk);
    av0 = 0;
    checks++; if (yv0 !== 8'h08) begin errors++; $display("FAIL pre_rst_full got=%h want=08", yv0); end
    rst = 1;
    #1;
    checks++; if (yv0 !== 8'h00 || y0 !== 64'h0) begin errors++; $display("FAIL midrst_out got yv=%h y=%h want 0", yv0, y0); end
    checks++; if (ar0 !== 1'b0) begin errors++; $display("FAIL midrst_a_ready got=%b want=0", ar0); end
    @(negedge clk);
    rst = 0; yr0 = '1;
    #1;
    checks++; if (ar0 !== 1'b1) begin errors++; $display("FAIL midrst_release got=%b want=1", ar0); end
  endtask

  task automatic test_route();
    int sels[5] = '{0, 1, 2, 7, 5};
    exp_t e;
    logic [63:0] ey;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        ey = '0; ey[e.ch*8 +: 8] = e.d;
        checks++; if (yv0 !== 8'(1 << e.ch)) begin errors++; $display("FAIL route_valid ch=%0d got=%h want=%h", e.ch, yv0, 8'(1 << e.ch)); end
        checks++; if (y0 !== ey) begin errors++; $display("FAIL route_data ch=%0d got=%h want=%h", e.ch, y0, ey); end
      end
      if (i < 5) begin
        checks++; if (ar0 !== 1'b1) begin errors++; $display("FAIL route_a_ready beat=%0d got=%b want=1", i, ar0); end
        a = 8'hA5; s = 3'(sels[i]); av0 = 1;
        sb.push_back('{sels[i], 8'hA5, 1'b0});
      end else av0 = 0;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [63:0] ey;
    @(negedge clk);
    yr0 = 8'hF7; a = 8'h3C; s = 3; av0 = 1;
    sb.push_back('{3, 8'h3C, 1'b0});
    @(negedge clk);
    a = 8'h5A; s = 6;
    sb.push_back('{6, 8'h5A, 1'b0});
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      e = sb[0];
      ey = '0; ey[e.ch*8 +: 8] = e.d;
      checks++; if (ar0 !== 1'b0) begin errors++; $display("FAIL stall_a_ready cyc=%0d got=%b want=0", i, ar0); end
      checks++; if (yv0 !== 8'h08 || y0 !== ey) begin errors++; $display("FAIL stall_hold cyc=%0d got yv=%h y=%h want yv=08 y=%h", i, yv0, y0, ey); end
    end
    yr0 = '1;
    #1;
    checks++; if (ar0 !== 1'b1) begin errors++; $display("FAIL unstall_a_ready got=%b want=1", ar0); end
    void'(sb.pop_front());
    @(negedge clk);
    av0 = 0;
    e = sb.pop_front();
    ey = '0; ey[e.ch*8 +: 8] = e.d;
    checks++; if (yv0 !== 8'(1 << e.ch) || y0 !== ey) begin errors++; $display("FAIL no_bubble got yv=%h y=%h want yv=%h y=%h", yv0, y0, 8'(1 << e.ch), ey); end
    @(negedge clk);
    checks++; if (yv0 !== 8'h00) begin errors++; $display("FAIL drained got=%h want=00", yv0); end
  endtask

  task automatic test_out_of_range();
    int sels[5] = '{7, 6, 2, 5, 0};
    exp_t e;
    logic [47:0] ey;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        ey = '0;
        if (!e.e) ey[e.ch*8 +: 8] = e.d;
        checks++; if (yv1 !== (e.e ? 6'h0 : 6'(1 << e.ch)) || y1 !== ey) begin errors++; $display("FAIL oor_out s=%0d got yv=%h y=%h want y=%h", e.ch, yv1, y1, ey); end
        checks++; if (err1 !== e.e) begin errors++; $display("FAIL oor_err s=%0d got=%b want=%b", e.ch, err1, e.e); end
      end
      if (i < 5) begin
        a = 8'(8'h70 + i); s = 3'(sels[i]); av1 = 1;
        sb.push_back('{sels[i], 8'(8'h70 + i), sels[i] >= 6});
      end else av1 = 0;
    end
    @(negedge clk);
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL oor_err_idle got=%b want=0", err1); end
  endtask

  task automatic test_packet();
    int   ts[8] = '{4, 1, 6, 1, 6, 2, 3, 0};
    logic tl[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int   tc[8] = '{4, 4, 4, 1, -1, -1, -1, 0};
    exp_t e;
    logic [47:0] ey;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        ey = '0;
        if (!e.e) ey[e.ch*8 +: 8] = e.d;
        checks++; if (yv2 !== (e.e ? 6'h0 : 6'(1 << e.ch)) || y2 !== ey) begin errors++; $display("FAIL pkt_out beat=%0d got yv=%h y=%h want ch=%0d y=%h", i - 1, yv2, y2, e.ch, ey); end
        checks++; if (err2 !== e.e) begin errors++; $display("FAIL pkt_err beat=%0d got=%b want=%b", i - 1, err2, e.e); end
      end
      if (i < 8) begin
        a = 8'(8'h10 + i); s = 3'(ts[i]); a_last = tl[i]; av2 = 1;
        sb.push_back('{tc[i], 8'(8'h10 + i), tc[i] < 0});
      end else begin av2 = 0; a_last = 0; end
    end
  endtask

  task automatic test_reset_mid_packet();
    exp_t e;
    logic [47:0] ey;
    @(negedge clk);
    a = 8'hA1; s = 4; a_last = 0; av2 = 1;
    sb.push_back('{4, 8'hA1, 1'b0});
    @(negedge clk);
    e = sb.pop_front();
    ey = '0; ey[e.ch*8 +: 8] = e.d;
    checks++; if (yv2 !== 6'h10 || y2 !== ey) begin errors++; $display("FAIL mid_beat0 got yv=%h y=%h want yv=10 y=%h", yv2, y2, ey); end
    a = 8'hA2; s = 1;
    sb.push_back('{4, 8'hA2, 1'b0});
    @(negedge clk);
    e = sb.pop_front();
    ey = '0; ey[e.ch*8 +: 8] = e.d;
    checks++; if (yv2 !== 6'h10 || y2 !== ey) begin errors++; $display("FAIL mid_beat1 got yv=%h y=%h want yv=10 y=%h", yv2, y2, ey); end
    av2 = 0; rst = 1;
    #1;
    checks++; if (yv2 !== 6'h0 || y2 !== 48'h0 || ar2 !== 1'b0) begin errors++; $display("FAIL mid_rst got yv=%h y=%h ar=%b want 0", yv2, y2, ar2); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    a = 8'hA3; s = 2; av2 = 1;
    sb.push_back('{2, 8'hA3, 1'b0});
    @(negedge clk);
    av2 = 0;
    e = sb.pop_front();
    ey = '0; ey[e.ch*8 +: 8] = e.d;
    checks++; if (yv2 !== 6'h04 || y2 !== ey) begin errors++; $display("FAIL post_rst_route got yv=%h y=%h want yv=04 y=%h", yv2, y2, ey); end
  endtask

  initial begin
    test_reset();
    test_route();
    test_backpressure();
    test_out_of_range();
    test_packet();
    test_reset_mid_packet();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux1_n_stream.md
# demux1_n_stream

Parametrised, registered 1-to-N stream demultiplexer: the successor to the combinational 1-to-8 demux. It routes a DATA_W-bit input beat to one of N output channels under a valid/ready handshake, with one output register stage. An optional packet mode locks the channel selection for the length of a packet. It sits between a single producer and N independent consumers, each of which may stall.

## Interface
Parameters:
- N, 8, number of output channels (2..64; need not be a power of two)
- DATA_W, 8, beat width in bits
- PKT_MODE, 0, 0 = per-beat select; 1 = select sampled on first beat of packet and held until last
- SEL_W (localparam), $clog2(N), select width

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- a  input  DATA_W  input beat data
- a_valid  input  1  input beat present
- a_last  input  1  last beat of packet (ignored when PKT_MODE=0)
- s  input  SEL_W  channel select, sampled with the beat
- a_ready  output  1  block can accept a beat this cycle
- y  output  N*DATA_W  channel k occupies y[k*DATA_W +: DATA_W]
- y_valid  output  N  per-channel valid, at most one bit set
- y_ready  input  N  per-channel consumer ready
- err  output  1  one-cycle pulse: beat dropped due to out-of-range select

## Operation
- Single-entry holding register: buf_data, buf_ch, buf_full.
- Accept = a_valid & a_ready. a_ready = !rst & (!buf_full | y_ready[buf_ch]).
- Effective channel: PKT_MODE=0 or state IDLE -> s; state LOCKED -> lock_ch.
- Accept with effective channel < N: buf_data<=a, buf_ch<=channel, buf_full<=1.
- Accept with effective channel >= N: beat consumed and discarded, buf_full cleared if it was drained this cycle, err=1 next cycle.
- Output: y_valid[k] = buf_full & (buf_ch==k). Slot buf_ch carries buf_data; all other slots are 0 (demux convention).
- Drain: y_valid[buf_ch] & y_ready[buf_ch] -> buf_full<=0, unless reloaded by a same-cycle accept.
- Packet FSM (PKT_MODE=1 only), states IDLE, LOCKED:
  - IDLE: accept with a_last=0 -> LOCKED, lock_ch<=s. Accept with a_last=1 is a single-beat packet and stays in IDLE.
  - LOCKED: s is ignored. Accept with a_last=1 -> IDLE.
  - An out-of-range s on the first beat locks onto the invalid channel, so the whole packet is dropped and err pulses once per beat.
- y_ready on non-selected channels is ignored.

## Timing
- Reset values: y=0, y_valid=0, err=0, buf_full=0, state=IDLE, lock_ch=0. a_ready=0 while rst is high and 1 in the first cycle after release.
- Latency: accept edge -> y_valid high the same edge (registered), i.e. visible the cycle after a_valid & a_ready.
- Throughput: 1 beat/cycle while the selected consumer holds ready, including back-to-back beats to different channels.
- Simultaneous drain and accept: the register is reloaded and y_valid stays high, moving to the new channel if different. There is no bubble.
- Stall: while buf_full & !y_ready[buf_ch], a_ready=0 and y and y_valid hold stable.
- Reset mid-packet: FSM returns to IDLE, the buffered beat is lost, and the next beat is treated as first of a packet.
- err is registered and high for exactly one cycle per dropped beat.

## Structure
- Shared package demux_pkg: state typedef (IDLE, LOCKED) and the clog2 helper used for SEL_W.
- Sub-module demux1_n_decode: combinational SEL_W -> N one-hot decoder with an out-of-range flag. It is used for y_valid and for gating the y slots.
- Top level holds the buffer register, handshake logic and packet FSM.

## Test plan
- Reset/idle: assert rst mid-stream with buf_full=1 -> y=0, y_valid=0, a_ready=0. After release, a_ready=1.
- Per-beat routing, N=8, DATA_W=8, all y_ready=1: a=8'hA5 with s=0,1,2,7,5 on consecutive cycles -> y_valid=01,02,04,80,20 (hex) one cycle later, with A5 in the matching slot and the other slots 0.
- Backpressure: s=3, y_ready[3]=0 for 4 cycles -> a_ready=0 and y/y_valid=8'h08 stable. Raising y_ready[3] -> drain and a new accept in the same cycle with no bubble.
- Out-of-range, N=6: s=7 accepted -> no y_valid, err high for one cycle. Next beat with s=2 routes normally.
- Packet mode, PKT_MODE=1: 3-beat packet, s=4 on beat 0, then s=1 and s=6 on beats 1-2 with a_last on beat 2 -> all three beats appear on channel 4. The following beat with s=1 goes to channel 1.
- Reset mid-packet: reset after beat 1 of a locked packet to channel 4, then a beat with s=2 -> routed to channel 2.
